// File: rtl/vcdl_delay_scanner.sv
// -----------------------------------------------------------------------------
// vcdl_delay_scanner
//
// Automatic delay calibrator for NUM_CH VCDL channels. Each channel's IDELAY
// tap is swept upward from 0. At every tap the synchronised feedback bit is
// majority-sampled. The sweep stops at the first 0->1 transition, and the
// channel is then loaded with edge+EDGE_OFFSET, saturated to the top tap.
// While idle, a manual path can load any channel directly. delay_o/load_o drive
// IDELAYE2 CNTVALUEIN/LD directly.
//
// Ports
//   sysclk_i       sole clock
//   rst_n_i        asynchronous active-low reset
//   start_i        pulse: scan all channels (accepted in IDLE only)
//   manual_load_i  pulse: load manual_delay_i into manual_ch_i (IDLE only)
//   manual_ch_i    manual target channel; values >= NUM_CH are ignored
//   manual_delay_i manual tap value
//   fb_q_i         VCDL feedback bits, already synchronised to sysclk_i
//   delay_o        per-channel CNTVALUEIN, ch c = [c*TAP_BITS +: TAP_BITS]
//   load_o         per-channel LD strobe, one-cycle pulses, at most one high
//   edge_tap_o     edge tap found per channel in the last scan (0 on fail)
//   fail_o         sticky per channel: no edge found in the last scan
//   busy_o         high from the cycle after start accept until DONE
//   done_o         one-cycle pulse at scan completion
// -----------------------------------------------------------------------------
module vcdl_delay_scanner #(
    parameter int NUM_CH        = 4,
    parameter int TAP_BITS      = 5,
    parameter int SETTLE_CYCLES = 8,
    parameter int LOG2_NSAMP    = 4,
    parameter int EDGE_OFFSET   = 6
) (
    input  logic                         sysclk_i,
    input  logic                         rst_n_i,
    input  logic                         start_i,
    input  logic                         manual_load_i,
    input  logic [3:0]                   manual_ch_i,
    input  logic [TAP_BITS-1:0]          manual_delay_i,
    input  logic [NUM_CH-1:0]            fb_q_i,
    output logic [NUM_CH*TAP_BITS-1:0]   delay_o,
    output logic [NUM_CH-1:0]            load_o,
    output logic [NUM_CH*TAP_BITS-1:0]   edge_tap_o,
    output logic [NUM_CH-1:0]            fail_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int NSAMP   = 1 << LOG2_NSAMP;
    localparam int CNT_MAX = (SETTLE_CYCLES > NSAMP) ? SETTLE_CYCLES : NSAMP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [TAP_BITS-1:0]   TAP_MAX     = {TAP_BITS{1'b1}};
    localparam logic [CNT_W-1:0]      SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      SAMPLE_LAST = CNT_W'(NSAMP - 1);
    localparam logic [LOG2_NSAMP:0]   HALF_NSAMP  = (LOG2_NSAMP + 1)'(NSAMP / 2);
    localparam logic [3:0]            LAST_CH     = 4'(NUM_CH - 1);
    localparam logic [4:0]            NUM_CH_W    = 5'(NUM_CH);
    localparam logic [TAP_BITS:0]     OFFSET_W    = (TAP_BITS + 1)'(EDGE_OFFSET);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_EVAL   = 3'd4,
        S_APPLY  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // Final load value: edge + offset evaluated one bit wider so an overflow
    // saturates to the top tap instead of wrapping to a small delay.
    function automatic logic [TAP_BITS-1:0] sat_add_offset(input logic [TAP_BITS-1:0] edge_tap);
        logic [TAP_BITS:0] sum;
        sum = {1'b0, edge_tap} + OFFSET_W;
        if (sum > {1'b0, TAP_MAX}) begin
            sat_add_offset = TAP_MAX;
        end else begin
            sat_add_offset = sum[TAP_BITS-1:0];
        end
    endfunction

    // Registered state
    state_t                        r_state;
    logic [3:0]                    r_ch;
    logic [TAP_BITS-1:0]           r_tap;
    logic [CNT_W-1:0]              r_cnt;
    logic [LOG2_NSAMP:0]           r_ones;
    logic                          r_prev;
    logic [NUM_CH*TAP_BITS-1:0]    r_delay;
    logic [NUM_CH-1:0]             r_load;
    logic [NUM_CH*TAP_BITS-1:0]    r_edge_tap;
    logic [NUM_CH-1:0]             r_fail;
    logic                          r_busy;
    logic                          r_done;

    // Next-state values
    state_t                        w_state_nxt;
    logic [3:0]                    w_ch_nxt;
    logic [TAP_BITS-1:0]           w_tap_nxt;
    logic [CNT_W-1:0]              w_cnt_nxt;
    logic [LOG2_NSAMP:0]           w_ones_nxt;
    logic                          w_prev_nxt;
    logic [NUM_CH*TAP_BITS-1:0]    w_delay_nxt;
    logic [NUM_CH-1:0]             w_load_nxt;
    logic [NUM_CH*TAP_BITS-1:0]    w_edge_tap_nxt;
    logic [NUM_CH-1:0]             w_fail_nxt;
    logic                          w_busy_nxt;
    logic                          w_done_nxt;

    // Single write port into the per-channel output arrays
    logic                          w_wr_en;
    logic [3:0]                    w_wr_ch;
    logic [TAP_BITS-1:0]           w_wr_val;
    logic                          w_edge_wr;
    logic [TAP_BITS-1:0]           w_edge_val;
    logic                          w_fail_set;
    logic                          w_clear;
    logic [NUM_CH-1:0]             w_wr_oh;

    // Feedback of the channel under scan, and the majority decision
    logic [NUM_CH-1:0]             w_fb_shift;
    logic                          w_fb_bit;
    logic                          w_bit;

    assign w_fb_shift = fb_q_i >> r_ch;
    assign w_fb_bit   = w_fb_shift[0];
    // A tie (exactly half ones) resolves to 1.
    assign w_bit      = (r_ones >= HALF_NSAMP);

    // Next-state and write-port control for the scan FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_tap_nxt   = r_tap;
        w_cnt_nxt   = r_cnt;
        w_ones_nxt  = r_ones;
        w_prev_nxt  = r_prev;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_ch     = r_ch;
        w_wr_val    = r_tap;
        w_edge_wr   = 1'b0;
        w_edge_val  = {TAP_BITS{1'b0}};
        w_fail_set  = 1'b0;
        w_clear     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    // Start wins over a simultaneous manual request.
                    w_clear     = 1'b1;
                    w_ch_nxt    = 4'd0;
                    w_tap_nxt   = {TAP_BITS{1'b0}};
                    w_prev_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_wr_en     = 1'b1;
                    w_wr_ch     = 4'd0;
                    w_wr_val    = {TAP_BITS{1'b0}};
                    w_state_nxt = S_LOAD;
                end else if (manual_load_i && ({1'b0, manual_ch_i} < NUM_CH_W)) begin
                    w_wr_en     = 1'b1;
                    w_wr_ch     = manual_ch_i;
                    w_wr_val    = manual_delay_i;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_LOAD: begin
                w_cnt_nxt   = {CNT_W{1'b0}};
                w_state_nxt = S_SETTLE;
            end

            S_SETTLE: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_ones_nxt  = {(LOG2_NSAMP + 1){1'b0}};
                    w_state_nxt = S_SAMPLE;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1'b1);
                    w_state_nxt = S_SETTLE;
                end
            end

            S_SAMPLE: begin
                w_ones_nxt = r_ones + (LOG2_NSAMP + 1)'(w_fb_bit);
                if (r_cnt == SAMPLE_LAST) begin
                    w_state_nxt = S_EVAL;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1'b1);
                    w_state_nxt = S_SAMPLE;
                end
            end

            S_EVAL: begin
                // A rise seen at tap 0 has no predecessor, so it never counts.
                if ((r_tap != {TAP_BITS{1'b0}}) && !r_prev && w_bit) begin
                    w_edge_wr   = 1'b1;
                    w_edge_val  = r_tap;
                    w_wr_en     = 1'b1;
                    w_wr_val    = sat_add_offset(r_tap);
                    w_state_nxt = S_APPLY;
                end else begin
                    w_prev_nxt = w_bit;
                    if (r_tap == TAP_MAX) begin
                        w_fail_set  = 1'b1;
                        w_edge_wr   = 1'b1;
                        w_edge_val  = {TAP_BITS{1'b0}};
                        w_wr_en     = 1'b1;
                        w_wr_val    = {TAP_BITS{1'b0}};
                        w_state_nxt = S_APPLY;
                    end else begin
                        w_tap_nxt   = r_tap + TAP_BITS'(1'b1);
                        w_wr_en     = 1'b1;
                        w_wr_val    = r_tap + TAP_BITS'(1'b1);
                        w_state_nxt = S_LOAD;
                    end
                end
            end

            S_APPLY: begin
                if (r_ch == LAST_CH) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_ch_nxt    = r_ch + 4'd1;
                    w_tap_nxt   = {TAP_BITS{1'b0}};
                    w_prev_nxt  = 1'b0;
                    w_wr_en     = 1'b1;
                    w_wr_ch     = r_ch + 4'd1;
                    w_wr_val    = {TAP_BITS{1'b0}};
                    w_state_nxt = S_LOAD;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Apply the write port to the per-channel delay, load, edge and fail arrays.
    always_comb begin
        // A channel index past NUM_CH shifts out to an all-zero select.
        w_wr_oh        = NUM_CH'(1'b1) << w_wr_ch;
        w_delay_nxt    = r_delay;
        w_load_nxt     = {NUM_CH{1'b0}};
        w_edge_tap_nxt = w_clear ? {(NUM_CH * TAP_BITS){1'b0}} : r_edge_tap;
        w_fail_nxt     = w_clear ? {NUM_CH{1'b0}} : r_fail;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_wr_oh[c] && w_wr_en) begin
                w_delay_nxt[c*TAP_BITS +: TAP_BITS] = w_wr_val;
                w_load_nxt[c]                       = 1'b1;
            end else begin
                w_load_nxt[c] = 1'b0;
            end
            if (w_wr_oh[c] && w_edge_wr) begin
                w_edge_tap_nxt[c*TAP_BITS +: TAP_BITS] = w_edge_val;
                w_fail_nxt[c]                          = w_fail_set;
            end else begin
                w_fail_nxt[c] = w_fail_nxt[c];
            end
        end
    end

    // State and output registers; reset aborts any scan and zeroes all outputs.
    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= S_IDLE;
            r_ch       <= 4'd0;
            r_tap      <= {TAP_BITS{1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_ones     <= {(LOG2_NSAMP + 1){1'b0}};
            r_prev     <= 1'b0;
            r_delay    <= {(NUM_CH * TAP_BITS){1'b0}};
            r_load     <= {NUM_CH{1'b0}};
            r_edge_tap <= {(NUM_CH * TAP_BITS){1'b0}};
            r_fail     <= {NUM_CH{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ch       <= w_ch_nxt;
            r_tap      <= w_tap_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ones     <= w_ones_nxt;
            r_prev     <= w_prev_nxt;
            r_delay    <= w_delay_nxt;
            r_load     <= w_load_nxt;
            r_edge_tap <= w_edge_tap_nxt;
            r_fail     <= w_fail_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign delay_o    = r_delay;
    assign load_o     = r_load;
    assign edge_tap_o = r_edge_tap;
    assign fail_o     = r_fail;
    assign busy_o     = r_busy;
    assign done_o     = r_done;

endmodule

// File: tb/tb_vcdl_delay_scanner.sv
// -----------------------------------------------------------------------------
// tb_vcdl_delay_scanner
//
// Drives per-channel feedback from a behavioural IDELAY model: each channel
// holds the last tap strobed in by load_o, and the feedback for that tap is a
// 16-cycle periodic pattern with a programmed number of ones. Every scan pushes
// its expected load sequence (channel, value) to a queue. A monitor pops and
// compares on each load_o pulse. Final edge, fail and delay values are checked
// at done_o.
// -----------------------------------------------------------------------------
module tb_vcdl_delay_scanner;

    localparam int NCH = 4;
    localparam int TB  = 5;
    localparam int NT  = 32;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 man_ld = 1'b0;
    logic [3:0]           man_ch = 4'd0;
    logic [TB-1:0]        man_dly = 5'd0;
    logic [NCH-1:0]       fb = 4'd0;
    logic [NCH*TB-1:0]    delay;
    logic [NCH-1:0]       load;
    logic [NCH*TB-1:0]    edge_tap;
    logic [NCH-1:0]       fail;
    logic                 busy;
    logic                 done;

    int checks = 0;
    int errors = 0;

    int prof [NCH][NT];
    int idl  [NCH];
    int exp_q [$];
    int phase = 0;
    logic [NCH*TB-1:0]    exp_edge;
    logic [NCH*TB-1:0]    exp_delay;
    logic [NCH-1:0]       exp_fail;

    vcdl_delay_scanner dut (
        .sysclk_i       (clk),
        .rst_n_i        (rst_n),
        .start_i        (start),
        .manual_load_i  (man_ld),
        .manual_ch_i    (man_ch),
        .manual_delay_i (man_dly),
        .fb_q_i         (fb),
        .delay_o        (delay),
        .load_o         (load),
        .edge_tap_o     (edge_tap),
        .fail_o         (fail),
        .busy_o         (busy),
        .done_o         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Feedback profile helpers: ones per 16 samples at each tap.
    task automatic set_step(input int c, input int e);
        for (int t = 0; t < NT; t++) prof[c][t] = (t >= e) ? 16 : 0;
    endtask

    task automatic set_const(input int c, input int ones);
        for (int t = 0; t < NT; t++) prof[c][t] = ones;
    endtask

    // Reference scan: expected load sequence and final per-channel results.
    task automatic build_scan();
        int prev;
        int e;
        int b;
        int fin;
        for (int c = 0; c < NCH; c++) begin
            prev = 0;
            e = -1;
            for (int t = 0; t < NT; t++) begin
                exp_q.push_back(c * 64 + t);
                b = (prof[c][t] >= 8) ? 1 : 0;
                if (t > 0 && prev == 0 && b == 1) begin
                    e = t;
                    break;
                end
                prev = b;
            end
            if (e < 0) fin = 0;
            else fin = (e + 6 > 31) ? 31 : e + 6;
            exp_q.push_back(c * 64 + fin);
            exp_edge[c*TB +: TB]  = TB'((e < 0) ? 0 : e);
            exp_delay[c*TB +: TB] = TB'(fin);
            exp_fail[c]           = (e < 0) ? 1'b1 : 1'b0;
        end
    endtask

    task automatic do_start(input bit with_manual);
        @(negedge clk);
        build_scan();
        start   = 1'b1;
        man_ld  = with_manual;
        man_ch  = 4'd1;
        man_dly = 5'd5;
        @(negedge clk);
        start  = 1'b0;
        man_ld = 1'b0;
        chk("busy_rise", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, "_edge"}, 32'(edge_tap), 32'(exp_edge));
        chk({tag, "_fail"}, 32'(fail), 32'(exp_fail));
        chk({tag, "_delay"}, 32'(delay), 32'(exp_delay));
        chk({tag, "_loads_left"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    // Load monitor / scoreboard and IDELAY + feedback model.
    initial begin
        for (int c = 0; c < NCH; c++) idl[c] = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (load !== 4'd0) begin
                    int ch;
                    int got;
                    int exp;
                    ch = 0;
                    for (int c = 0; c < NCH; c++) if (load[c]) ch = c;
                    chk("load_onehot", 32'($countones(load)), 32'd1);
                    got = ch * 64 + int'(delay[ch*TB +: TB]);
                    exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                    chk("load_seq", 32'(got), 32'(exp));
                    idl[ch] = int'(delay[ch*TB +: TB]);
                end
            end
            phase = (phase + 1) % 16;
            for (int c = 0; c < NCH; c++) fb[c] = (phase < prof[c][idl[c]]) ? 1'b1 : 1'b0;
        end
    end

    initial begin
        for (int c = 0; c < NCH; c++) set_const(c, 0);

        // Power-on reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_delay", 32'(delay), 32'd0);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_edge", 32'(edge_tap), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Scan 1: edge 10, saturating edge 29, no edge, tie at tap 12
        set_step(0, 10);
        set_step(1, 29);
        set_const(2, 16);
        set_step(3, 13);
        prof[3][12] = 8;
        do_start(1'b0);
        wait_done("scan1");

        // Manual load into channel 2
        @(negedge clk);
        man_ld = 1'b1; man_ch = 4'd2; man_dly = 5'd7;
        exp_q.push_back(2 * 64 + 7);
        @(negedge clk);
        man_ld = 1'b0;
        chk("man_load_o", 32'(load), 32'h4);
        chk("man_delay2", 32'(delay[2*TB +: TB]), 32'd7);
        @(negedge clk);
        chk("man_pulse_end", 32'(load), 32'd0);

        // Manual load to a non-existent channel
        man_ld = 1'b1; man_ch = 4'd9; man_dly = 5'd3;
        @(negedge clk);
        man_ld = 1'b0;
        chk("man_ch9_load", 32'(load), 32'd0);
        repeat (3) @(negedge clk);
        chk("man_ch9_q", 32'(exp_q.size()), 32'd0);

        // Scan 2 with a colliding manual request: 1->0->1 at tap 5, no edge,
        // edge at the top tap, and 7/16 at tap 12 (no edge there)
        set_const(0, 16);
        for (int t = 1; t < 5; t++) prof[0][t] = 0;
        set_const(1, 0);
        set_step(2, 31);
        set_step(3, 13);
        prof[3][12] = 7;
        do_start(1'b1);
        wait_done("scan2");

        // Reset mid-SAMPLE aborts the scan
        do_start(1'b0);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_delay", 32'(delay), 32'd0);
        chk("abort_load", 32'(load), 32'd0);
        chk("abort_edge", 32'(edge_tap), 32'd0);
        chk("abort_fail", 32'(fail), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_busy", 32'(busy), 32'd0);
            chk("post_rst_load", 32'(load), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
